// File: rtl/count_match_irq.sv
// count_match_irq: three Wishbone-programmed count comparators with sticky IRQs.
// Optional CAPTURE register built when COUNT_MATCH_IRQ_CAPTURE_EN is defined.
module count_match_irq #(
  parameter int unsigned BITS      = 30,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0020
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_dat_i,
  input  logic [31:0]     wbs_adr_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  input  logic [BITS-1:0] count,
  output logic [2:0]      user_irq
);

  localparam logic [2:0] OFF_CMP0 = 3'd0;
  localparam logic [2:0] OFF_CMP1 = 3'd1;
  localparam logic [2:0] OFF_CMP2 = 3'd2;
  localparam logic [2:0] OFF_CTRL = 3'd3;
  localparam logic [2:0] OFF_STAT = 3'd4;
  localparam logic [2:0] OFF_CAPT = 3'd5;

  logic [BITS-1:0] r_cmp0;
  logic [BITS-1:0] r_cmp1;
  logic [BITS-1:0] r_cmp2;
  logic [2:0]      r_ie;
  logic            r_gie;
  logic [2:0]      r_status;
  logic [2:0]      r_eq_q;
  logic            r_ack;
  logic [31:0]     r_dat;

  logic            w_hit_win;
  logic            w_valid;
  logic            w_fire;
  logic            w_wr;
  logic [2:0]      w_off;
  logic [31:0]     w_bmask;
  logic [BITS-1:0] w_mask;
  logic [BITS-1:0] w_wdat;
  logic [2:0]      w_eq;
  logic [2:0]      w_hit;
  logic [2:0]      w_w1c;
  logic [31:0]     w_rdata;
  logic            w_unused;

  assign w_hit_win = wbs_adr_i[31:5] == BASE_ADDR[31:5];
  assign w_valid   = wbs_cyc_i & wbs_stb_i & w_hit_win;
  // the cycle that raises ack is the one that reads and writes
  assign w_fire    = w_valid & ~r_ack;
  assign w_wr      = w_fire & wbs_we_i;
  assign w_off     = wbs_adr_i[4:2];

  assign w_bmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                    {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign w_mask  = w_bmask[BITS-1:0];
  assign w_wdat  = wbs_dat_i[BITS-1:0] & w_mask;

  assign w_eq[0] = count == r_cmp0;
  assign w_eq[1] = count == r_cmp1;
  assign w_eq[2] = count == r_cmp2;
  assign w_hit   = w_eq & ~r_eq_q;

  assign w_w1c = (w_wr && w_off == OFF_STAT && wbs_sel_i[0])
               ? wbs_dat_i[2:0] : 3'b000;

  assign w_unused = &{1'b0, wbs_adr_i[1:0], wbs_dat_i[31:BITS]};

`ifdef COUNT_MATCH_IRQ_CAPTURE_EN
  logic [BITS-1:0] r_capture;

  // latest count seen on a CMP0 rising match
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_capture <= '0;
    end else if (w_hit[0]) begin
      r_capture <= count;
    end
  end
`endif

  // register read mux, pre-write values
  always_comb begin
    w_rdata = 32'h0;
    case (w_off)
      OFF_CMP0: w_rdata = {{(32-BITS){1'b0}}, r_cmp0};
      OFF_CMP1: w_rdata = {{(32-BITS){1'b0}}, r_cmp1};
      OFF_CMP2: w_rdata = {{(32-BITS){1'b0}}, r_cmp2};
      OFF_CTRL: w_rdata = {28'h0, r_gie, r_ie};
      OFF_STAT: w_rdata = {29'h0, r_status};
`ifdef COUNT_MATCH_IRQ_CAPTURE_EN
      OFF_CAPT: w_rdata = {{(32-BITS){1'b0}}, r_capture};
`else
      OFF_CAPT: w_rdata = 32'h0;
`endif
      default:  w_rdata = 32'h0;
    endcase
  end

  // bus handshake and registered read data
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack <= 1'b0;
      r_dat <= 32'h0;
    end else begin
      r_ack <= w_fire;
      r_dat <= w_fire ? w_rdata : 32'h0;
    end
  end

  // compare values, byte-lane writes
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_cmp0 <= '0;
      r_cmp1 <= '0;
      r_cmp2 <= '0;
    end else if (w_wr) begin
      if (w_off == OFF_CMP0) r_cmp0 <= (r_cmp0 & ~w_mask) | w_wdat;
      if (w_off == OFF_CMP1) r_cmp1 <= (r_cmp1 & ~w_mask) | w_wdat;
      if (w_off == OFF_CMP2) r_cmp2 <= (r_cmp2 & ~w_mask) | w_wdat;
    end
  end

  // interrupt enables
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ie  <= 3'b000;
      r_gie <= 1'b0;
    end else if (w_wr && w_off == OFF_CTRL && wbs_sel_i[0]) begin
      r_ie  <= wbs_dat_i[2:0];
      r_gie <= wbs_dat_i[3];
    end
  end

  // edge detect; reset high so a standing match does not fire
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_eq_q <= 3'b111;
    end else begin
      r_eq_q <= w_eq;
    end
  end

  // sticky status, a new hit beats a same-cycle clear
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_status <= 3'b000;
    end else begin
      r_status <= (r_status & ~w_w1c) | w_hit;
    end
  end

  // reset kills an in-flight ack immediately
  assign wbs_ack_o = r_ack & ~wb_rst_i;
  assign wbs_dat_o = wbs_ack_o ? r_dat : 32'h0;
  assign user_irq  = r_status & r_ie & {3{r_gie}};

endmodule

// File: tb/tb_count_match_irq.sv
// tb_count_match_irq: directed stimulus with a per-cycle reference model.
// Honours COUNT_MATCH_IRQ_CAPTURE_EN the same way as the design.
module tb_count_match_irq;

  localparam int unsigned BITS = 30;
  localparam logic [31:0] BASE = 32'h3000_0020;

  logic            clk = 1'b0;
  logic            rst;
  logic            cyc;
  logic            stb;
  logic            we;
  logic [3:0]      sel;
  logic [31:0]     dat_i;
  logic [31:0]     adr;
  logic            ack;
  logic [31:0]     dat_o;
  logic [BITS-1:0] count;
  logic [2:0]      irq;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  count_match_irq #(.BITS(BITS), .BASE_ADDR(BASE)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_dat_i (dat_i),
    .wbs_adr_i (adr),
    .wbs_ack_o (ack),
    .wbs_dat_o (dat_o),
    .count     (count),
    .user_irq  (irq)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [BITS-1:0] m_cmp [3];
  logic [2:0]      m_ie;
  logic            m_gie;
  logic [2:0]      m_st;
  logic [2:0]      m_prev;
  logic [BITS-1:0] m_cap;
  logic            m_ack;
  logic [31:0]     m_dat;

  function automatic logic [31:0] m_read(input logic [2:0] off);
    case (off)
      3'd0, 3'd1, 3'd2: return 32'(m_cmp[off]);
      3'd3: return {28'h0, m_gie, m_ie};
      3'd4: return {29'h0, m_st};
`ifdef COUNT_MATCH_IRQ_CAPTURE_EN
      3'd5: return 32'(m_cap);
`endif
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    logic [2:0]  hits;
    logic        fire;
    logic [31:0] rd;
    logic [31:0] bm;
    logic [31:0] nv;
    if (rst) begin
      for (int n = 0; n < 3; n++) m_cmp[n] = '0;
      m_ie = 0; m_gie = 0; m_st = 0; m_prev = 3'b111;
      m_cap = '0; m_ack = 0; m_dat = 0;
    end else begin
      fire = cyc && stb && (adr[31:5] == BASE[31:5]) && !m_ack;
      rd = m_read(adr[4:2]);
      for (int n = 0; n < 3; n++) begin
        hits[n] = (count == m_cmp[n]) && !m_prev[n];
        m_prev[n] = (count == m_cmp[n]);
      end
      bm = 0;
      for (int b = 0; b < 4; b++) if (sel[b]) bm[8*b +: 8] = 8'hFF;
      if (fire && we) begin
        if (adr[4:2] < 3) begin
          nv = (32'(m_cmp[adr[4:2]]) & ~bm) | (dat_i & bm);
          m_cmp[adr[4:2]] = nv[BITS-1:0];
        end
        if (adr[4:2] == 3 && sel[0]) {m_gie, m_ie} = dat_i[3:0];
        if (adr[4:2] == 4 && sel[0]) m_st = m_st & ~dat_i[2:0];
      end
      m_st = m_st | hits;
      if (hits[0]) m_cap = count;
      m_ack = fire;
      m_dat = fire ? rd : 32'h0;
    end
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    logic        e_ack;
    logic [31:0] e_dat;
    logic [2:0]  e_irq;
    if (chk_en) begin
      e_ack = m_ack & ~rst;
      e_dat = e_ack ? m_dat : 32'h0;
      e_irq = m_st & m_ie & {3{m_gie}};
      n_cmp++;
      if (ack !== e_ack || dat_o !== e_dat || irq !== e_irq) begin
        n_err++;
        $display("FAIL cycle t=%0t ack=%b want %b dat=%h want %h irq=%b want %b",
                 $time, ack, e_ack, dat_o, e_dat, irq, e_irq);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    cyc = 1; stb = 1; we = 1; adr = a; dat_i = d; sel = s;
    tick(1);
    chk("wr_ack", 32'(ack), 32'h1);
    cyc = 0; stb = 0; we = 0; sel = 0; dat_i = 0;
    tick(1);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    cyc = 1; stb = 1; we = 0; adr = a;
    chk("rd_ack_pre", 32'(ack), 32'h0);
    tick(1);
    chk("rd_ack", 32'(ack), 32'h1);
    d = dat_o;
    cyc = 0; stb = 0;
    tick(1);
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a,
                        input logic [31:0] exp);
    logic [31:0] d;
    wb_read(a, d);
    chk(nm, d, exp);
  endtask

  initial begin
    rst = 1; cyc = 0; stb = 0; we = 0; sel = 0;
    dat_i = 0; adr = 0; count = 0;
    @(posedge clk);
    #1 chk_en = 1'b1;
    tick(2);
    rst = 0;

    // standing equality out of reset must not fire
    tick(10);
    chk("rst_irq", 32'(irq), 32'h0);
    rd_chk("rst_status", BASE + 32'h10, 32'h0);
    rd_chk("rst_ctrl", BASE + 32'h0C, 32'h0);

    // CMP1 rising match on a ramp
    wb_write(BASE + 32'h04, 32'h15, 4'hF);
    wb_write(BASE + 32'h0C, 32'hA, 4'hF);
    for (int c = 'h10; c <= 'h20; c++) begin
      count = BITS'(c);
      tick(1);
      if (c == 'h15) chk("ramp_irq", 32'(irq), 32'h2);
    end
    rd_chk("ramp_status", BASE + 32'h10, 32'h2);
    wb_write(BASE + 32'h10, 32'h2, 4'hF);
    chk("w1c_irq", 32'(irq), 32'h0);

    // held count fires exactly once
    count = 'h15;
    tick(1);
    chk("hold_irq", 32'(irq), 32'h2);
    wb_write(BASE + 32'h10, 32'h2, 4'hF);
    tick(20);
    chk("hold_irq_low", 32'(irq), 32'h0);
    rd_chk("hold_status", BASE + 32'h10, 32'h0);

    // hit and W1C on the same edge
    wb_write(BASE + 32'h00, 32'h30, 4'hF);
    count = 'h30;
    tick(1);
    rd_chk("cmp0_status", BASE + 32'h10, 32'h1);
    count = 'h2F;
    tick(1);
    count = 'h30;
    wb_write(BASE + 32'h10, 32'h1, 4'hF);
    rd_chk("set_wins", BASE + 32'h10, 32'h1);
    wb_write(BASE + 32'h0C, 32'hB, 4'hF);
    chk("ie0_irq", 32'(irq), 32'h1);

    // byte lanes and window decode
    wb_write(BASE + 32'h08, 32'h12345678, 4'hF);
    wb_write(BASE + 32'h08, 32'h00000003, 4'h1);
    rd_chk("sel_cmp2", BASE + 32'h08, 32'h12345603);
    cyc = 1; stb = 1; we = 0; adr = BASE + 32'h40;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("no_ack", 32'(ack), 32'h0);
    end
    cyc = 0; stb = 0;
    tick(1);

    // capture of the CMP0 match count
    wb_write(BASE + 32'h10, 32'h7, 4'hF);
    wb_write(BASE + 32'h00, 32'h7, 4'hF);
    for (int c = 4; c <= 9; c++) begin
      count = BITS'(c);
      tick(1);
    end
`ifdef COUNT_MATCH_IRQ_CAPTURE_EN
    rd_chk("capture", BASE + 32'h14, 32'h7);
`else
    rd_chk("capture_rsvd", BASE + 32'h14, 32'h0);
`endif
    rd_chk("rsvd6", BASE + 32'h18, 32'h0);

    // compare written to the live count
    wb_write(BASE + 32'h10, 32'h7, 4'hF);
    wb_write(BASE + 32'h00, 32'h9, 4'hF);
    chk("wr_eq_irq", 32'(irq), 32'h1);

    // zero compare fires on wrap
    wb_write(BASE + 32'h10, 32'h7, 4'hF);
    wb_write(BASE + 32'h08, 32'h0, 4'hF);
    count = {BITS{1'b1}};
    tick(1);
    count = '0;
    tick(1);
    rd_chk("wrap_status", BASE + 32'h10, 32'h4);

    // reset in the middle of an acked read
    cyc = 1; stb = 1; we = 0; adr = BASE + 32'h0C;
    tick(1);
    chk("pre_rst_ack", 32'(ack), 32'h1);
    rst = 1;
    #1 chk("rst_ack_drop", 32'(ack), 32'h0);
    cyc = 0; stb = 0;
    tick(2);
    rst = 0;
    tick(1);
    rd_chk("post_rst_ctrl", BASE + 32'h0C, 32'h0);
    rd_chk("post_rst_status", BASE + 32'h10, 32'h0);
    chk("post_rst_irq", 32'(irq), 32'h0);

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
